// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port among NumReq writeback sources.
// Winner is registered into a one-entry output stage; writes to x0 are accepted but never enabled.
module regfile_wb_arbiter #(
   parameter int NumReq   = 2,
   parameter int RegWidth = 32,
   parameter int RegDepth = 32,
   localparam int AW      = $clog2(RegDepth),
   localparam int PW      = $clog2(NumReq)
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           stall_i,
   input  logic [NumReq-1:0]              req_valid_i,
   input  logic [NumReq-1:0][AW-1:0]      req_addr_i,
   input  logic [NumReq-1:0][RegWidth-1:0] req_data_i,
   output logic [NumReq-1:0]              req_ready_o,
   output logic [AW-1:0]                  rd_addr_o,
   output logic [RegWidth-1:0]            rd_data_o,
   output logic                           rd_write_en_o,
   output logic                           busy_o
);

   logic [PW-1:0]       ptr_q, ptr_d;
   logic [PW-1:0]       win;
   logic                found;
   logic                hs;
   logic [AW-1:0]       addr_q, addr_d;
   logic [RegWidth-1:0] data_q, data_d;
   logic                we_q, we_d;

   // Search starts at ptr_q and wraps at NumReq, not at 2**PW.
   always_comb begin
      int idx;
      idx   = 0;
      win   = '0;
      found = 1'b0;
      for (int k = 0; k < NumReq; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NumReq) idx = idx - NumReq;
         if (!found && req_valid_i[PW'(idx)]) begin
            found = 1'b1;
            win   = PW'(idx);
         end
      end
   end

   // Reset gates ready combinationally so nothing handshakes while rst_i is high.
   assign hs = found && !stall_i && !rst_i;

   always_comb begin
      req_ready_o = '0;
      if (hs) req_ready_o[win] = 1'b1;
   end

   always_comb begin
      ptr_d  = ptr_q;
      addr_d = addr_q;
      data_d = data_q;
      we_d   = 1'b0;
      if (hs) begin
         ptr_d  = (win == PW'(NumReq - 1)) ? '0 : win + PW'(1);
         addr_d = req_addr_i[win];
         data_d = req_data_i[win];
         we_d   = (req_addr_i[win] != '0);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q  <= '0;
         addr_q <= '0;
         data_q <= '0;
         we_q   <= 1'b0;
      end else begin
         ptr_q  <= ptr_d;
         addr_q <= addr_d;
         data_q <= data_d;
         we_q   <= we_d;
      end
   end

   assign rd_addr_o     = addr_q;
   assign rd_data_o     = data_q;
   assign rd_write_en_o = we_q;
   assign busy_o        = we_q;

endmodule
